// File: rtl/uart_csr_arbiter.sv
// uart_csr_arbiter: shares the UART CSR port (write port + registered read
// port) between port 0 (host bus) and port 1 (debug/config loader).
// Round-robin by default; define UART_CSR_ARB_FIXED_PRIO_EN for fixed
// priority with port 0 always winning a tie.
// Reads take two cycles (issue + RD_WAIT), so each accepted read produces
// exactly one csr_ren pulse, which keeps read-to-clear status bits safe.
module uart_csr_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              resp0_valid,
  output logic [DATA_W-1:0] resp0_rdata,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              resp1_valid,
  output logic [DATA_W-1:0] resp1_rdata,
  output logic              csr_wen,
  output logic [ADDR_W-1:0] csr_wr_addr,
  output logic [DATA_W-1:0] csr_wr_data,
  output logic              csr_ren,
  output logic [ADDR_W-1:0] csr_rd_addr,
  input  logic [DATA_W-1:0] csr_rd_data,
  output logic              busy
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] RD_WAIT = 1'b1;

  logic [0:0]        state;
  logic [0:0]        state_nxt;
  logic              owner;      // port that issued the read in flight
  logic              gnt0;
  logic              gnt1;
  logic              can_grant;
  logic              accept;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Grants are only offered in IDLE and never while reset is held, so every
  // output is 0 during reset even if requesters keep valid high.
  assign can_grant = rst_n && (state == IDLE);

`ifdef UART_CSR_ARB_FIXED_PRIO_EN
  // Fixed priority: port 0 wins any tie.
  always_comb begin
    gnt0 = req0_valid;
    gnt1 = req1_valid && !req0_valid;
  end
`else
  logic last_grant;

  // Round-robin: a lone requester wins; on a tie the port that did not win
  // last time gets it.
  always_comb begin
    gnt0 = req0_valid && (!req1_valid || last_grant);
    gnt1 = req1_valid && (!req0_valid || !last_grant);
  end

  // Remember the most recent winner; reset value 1 lets port 0 take the
  // first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last_grant <= 1'b1;
    else if (can_grant && (gnt0 || gnt1))
      last_grant <= gnt1;
  end
`endif

  assign accept     = can_grant && (gnt0 || gnt1);
  assign req0_ready = can_grant && gnt0;
  assign req1_ready = can_grant && gnt1;

  // Mux the winning request onto a single set of CSR fields.
  always_comb begin
    sel_write = req0_write;
    sel_addr  = req0_addr;
    sel_wdata = req0_wdata;
    if (gnt1) begin
      sel_write = req1_write;
      sel_addr  = req1_addr;
      sel_wdata = req1_wdata;
    end
  end

  // CSR strobes fire only in the accept cycle; address/data are zeroed
  // whenever the matching strobe is low.
  always_comb begin
    csr_wen     = accept && sel_write;
    csr_ren     = accept && !sel_write;
    csr_wr_addr = csr_wen ? sel_addr  : '0;
    csr_wr_data = csr_wen ? sel_wdata : '0;
    csr_rd_addr = csr_ren ? sel_addr  : '0;
  end

  // Next state: an accepted read parks one cycle in RD_WAIT for the
  // registered read data; RD_WAIT always returns to IDLE.
  always_comb begin
    state_nxt = IDLE;
    if (state == IDLE && csr_ren)
      state_nxt = RD_WAIT;
  end

  // State register; reset drops any read in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Owner of the read in flight, captured on the read accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      owner <= 1'b0;
    else if (csr_ren)
      owner <= gnt1;
  end

  // Route the registered read data to the owner only; rdata is 0 whenever
  // the matching valid is low.
  always_comb begin
    busy        = (state == RD_WAIT);
    resp0_valid = busy && !owner;
    resp1_valid = busy && owner;
    resp0_rdata = resp0_valid ? csr_rd_data : '0;
    resp1_rdata = resp1_valid ? csr_rd_data : '0;
  end

endmodule
